ldst_dataio_queue: RTL and testbench

Buffers load/store requests issued by execute port 3 on its DATAIO interface and forwards them in order to the data memory/MMU port. Decouples the execute stage from memory backpressure, allows up to P_OUTSTANDING requests in flight, and returns responses to the execute port in issue order.

---
 rtl/ldst_dataio_queue.sv | 181 ++++++++++++++++++
 tb/tb_ldst_dataio_queue.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_dataio_queue.sv
// -----------------------------------------------------------------------------
// ldst_dataio_queue
//
// In-order request queue between execute port 3 (DATAIO) and the data
// memory/MMU port. Requests are buffered in a P_DEPTH-entry FIFO. The head
// entry is offered to memory while fewer than P_OUTSTANDING requests are in
// flight. Memory responses arrive in issue order and are handed back to the
// execute port as a one-cycle oEXE_VALID pulse.
//
// Ports:
//   iCLOCK, inRESET          clock, synchronous active-low reset
//   iEXE_*  / oEXE_BUSY      request side from execute (push unless busy)
//   oEXE_VALID / oEXE_DATA   registered response pulse and held load data
//   oMEM_*  / iMEM_BUSY      head-entry request to memory (issue unless busy)
//   iMEM_VALID / iMEM_DATA   in-order memory responses
//   oQUEUE_EMPTY             no queued and no in-flight requests
//   oERR_UNEXPECTED          sticky flag: response arrived with none in flight
//   oPERF_STALL_CNT          cycles oMEM_REQ was held off by iMEM_BUSY
//
// Optional feature macro: LDST_DATAIO_QUEUE_STALL_CNT_EN
//   defined   -> saturating 32-bit stall counter drives oPERF_STALL_CNT
//   undefined -> oPERF_STALL_CNT is tied to zero
// -----------------------------------------------------------------------------
module ldst_dataio_queue #(
    parameter int P_DEPTH       = 4,
    parameter int P_DEPTH_N     = 2,
    parameter int P_OUTSTANDING = 2
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    // execute side
    input  logic        iEXE_REQ,
    output logic        oEXE_BUSY,
    input  logic        iEXE_RW,
    input  logic [1:0]  iEXE_ORDER,
    input  logic [3:0]  iEXE_MASK,
    input  logic [13:0] iEXE_TID,
    input  logic [1:0]  iEXE_MMUMOD,
    input  logic [31:0] iEXE_PDT,
    input  logic [31:0] iEXE_ADDR,
    input  logic [31:0] iEXE_DATA,
    output logic        oEXE_VALID,
    output logic [31:0] oEXE_DATA,
    // memory side
    output logic        oMEM_REQ,
    input  logic        iMEM_BUSY,
    output logic        oMEM_RW,
    output logic [1:0]  oMEM_ORDER,
    output logic [3:0]  oMEM_MASK,
    output logic [13:0] oMEM_TID,
    output logic [1:0]  oMEM_MMUMOD,
    output logic [31:0] oMEM_PDT,
    output logic [31:0] oMEM_ADDR,
    output logic [31:0] oMEM_DATA,
    input  logic        iMEM_VALID,
    input  logic [31:0] iMEM_DATA,
    // status
    output logic        oQUEUE_EMPTY,
    output logic        oERR_UNEXPECTED,
    output logic [31:0] oPERF_STALL_CNT
);

    typedef struct packed {
        logic        rw;
        logic [1:0]  order;
        logic [3:0]  mask;
        logic [13:0] tid;
        logic [1:0]  mmumod;
        logic [31:0] pdt;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    localparam logic [P_DEPTH_N:0]   L_DEPTH       = (P_DEPTH_N+1)'(P_DEPTH);
    localparam logic [P_DEPTH_N:0]   L_CNT_ONE     = (P_DEPTH_N+1)'(1);
    localparam logic [P_DEPTH_N-1:0] L_PTR_ONE     = P_DEPTH_N'(1);
    localparam logic [2:0]           L_OUTSTANDING = 3'(P_OUTSTANDING);

    req_t                 fifo [P_DEPTH];
    req_t                 push_entry;
    req_t                 head;
    logic [P_DEPTH_N-1:0] wr_ptr;
    logic [P_DEPTH_N-1:0] rd_ptr;
    logic [P_DEPTH_N:0]   count;
    logic [2:0]           outstanding;
    logic                 push;
    logic                 issue;
    logic                 resp_ok;

    assign push_entry = '{rw: iEXE_RW, order: iEXE_ORDER, mask: iEXE_MASK,
                          tid: iEXE_TID, mmumod: iEXE_MMUMOD, pdt: iEXE_PDT,
                          addr: iEXE_ADDR, data: iEXE_DATA};

    assign oEXE_BUSY    = (count == L_DEPTH);
    // Issue depends only on registered count, so a freshly pushed entry
    // cannot reach memory before the following cycle.
    assign oMEM_REQ     = (count != '0) && (outstanding < L_OUTSTANDING);
    assign oQUEUE_EMPTY = (count == '0) && (outstanding == '0);

    assign push    = iEXE_REQ && !oEXE_BUSY;
    assign issue   = oMEM_REQ && !iMEM_BUSY;
    assign resp_ok = iMEM_VALID && (outstanding != '0);

    assign head        = fifo[rd_ptr];
    assign oMEM_RW     = head.rw;
    assign oMEM_ORDER  = head.order;
    assign oMEM_MASK   = head.mask;
    assign oMEM_TID    = head.tid;
    assign oMEM_MMUMOD = head.mmumod;
    assign oMEM_PDT    = head.pdt;
    assign oMEM_ADDR   = head.addr;
    assign oMEM_DATA   = head.data;

    // NOTE: the payload array has no reset; validity is tracked entirely by
    // the pointers and count, so clearing it would only cost reset fan-out.
    always_ff @(posedge iCLOCK) begin
        if (push) begin
            fifo[wr_ptr] <= push_entry;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            outstanding     <= '0;
            oEXE_VALID      <= 1'b0;
            oEXE_DATA       <= '0;
            oERR_UNEXPECTED <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + L_PTR_ONE;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + L_PTR_ONE;
            end

            unique case ({push, issue})
                2'b10:   count <= count + L_CNT_ONE;
                2'b01:   count <= count - L_CNT_ONE;
                default: count <= count;
            endcase

            unique case ({issue, resp_ok})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase

            // Stores pulse too; oEXE_DATA otherwise holds the last response.
            oEXE_VALID <= resp_ok;
            if (resp_ok) begin
                oEXE_DATA <= iMEM_DATA;
            end

            if (iMEM_VALID && (outstanding == '0)) begin
                oERR_UNEXPECTED <= 1'b1;
            end
        end
    end

`ifdef LDST_DATAIO_QUEUE_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            stall_cnt <= '0;
        end else if (oMEM_REQ && iMEM_BUSY && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign oPERF_STALL_CNT = stall_cnt;
`else
    assign oPERF_STALL_CNT = 32'h0;
`endif

endmodule

// File: tb/tb_ldst_dataio_queue.sv
// -----------------------------------------------------------------------------
// tb_ldst_dataio_queue
//
// Directed bench for ldst_dataio_queue (P_DEPTH=4, P_OUTSTANDING=2).
// Accepted requests are pushed to exp_req; a negedge monitor pops and
// compares them whenever the DUT issues. Memory responses driven by the bench
// push their data to exp_resp; the monitor compares each oEXE_VALID pulse.
// -----------------------------------------------------------------------------
module tb_ldst_dataio_queue;

    logic        iCLOCK;
    logic        inRESET;
    logic        iEXE_REQ;
    logic        oEXE_BUSY;
    logic        iEXE_RW;
    logic [1:0]  iEXE_ORDER;
    logic [3:0]  iEXE_MASK;
    logic [13:0] iEXE_TID;
    logic [1:0]  iEXE_MMUMOD;
    logic [31:0] iEXE_PDT;
    logic [31:0] iEXE_ADDR;
    logic [31:0] iEXE_DATA;
    logic        oEXE_VALID;
    logic [31:0] oEXE_DATA;
    logic        oMEM_REQ;
    logic        iMEM_BUSY;
    logic        oMEM_RW;
    logic [1:0]  oMEM_ORDER;
    logic [3:0]  oMEM_MASK;
    logic [13:0] oMEM_TID;
    logic [1:0]  oMEM_MMUMOD;
    logic [31:0] oMEM_PDT;
    logic [31:0] oMEM_ADDR;
    logic [31:0] oMEM_DATA;
    logic        iMEM_VALID;
    logic [31:0] iMEM_DATA;
    logic        oQUEUE_EMPTY;
    logic        oERR_UNEXPECTED;
    logic [31:0] oPERF_STALL_CNT;

    ldst_dataio_queue #(
        .P_DEPTH      (4),
        .P_DEPTH_N    (2),
        .P_OUTSTANDING(2)
    ) dut (
        .iCLOCK         (iCLOCK),
        .inRESET        (inRESET),
        .iEXE_REQ       (iEXE_REQ),
        .oEXE_BUSY      (oEXE_BUSY),
        .iEXE_RW        (iEXE_RW),
        .iEXE_ORDER     (iEXE_ORDER),
        .iEXE_MASK      (iEXE_MASK),
        .iEXE_TID       (iEXE_TID),
        .iEXE_MMUMOD    (iEXE_MMUMOD),
        .iEXE_PDT       (iEXE_PDT),
        .iEXE_ADDR      (iEXE_ADDR),
        .iEXE_DATA      (iEXE_DATA),
        .oEXE_VALID     (oEXE_VALID),
        .oEXE_DATA      (oEXE_DATA),
        .oMEM_REQ       (oMEM_REQ),
        .iMEM_BUSY      (iMEM_BUSY),
        .oMEM_RW        (oMEM_RW),
        .oMEM_ORDER     (oMEM_ORDER),
        .oMEM_MASK      (oMEM_MASK),
        .oMEM_TID       (oMEM_TID),
        .oMEM_MMUMOD    (oMEM_MMUMOD),
        .oMEM_PDT       (oMEM_PDT),
        .oMEM_ADDR      (oMEM_ADDR),
        .oMEM_DATA      (oMEM_DATA),
        .iMEM_VALID     (iMEM_VALID),
        .iMEM_DATA      (iMEM_DATA),
        .oQUEUE_EMPTY   (oQUEUE_EMPTY),
        .oERR_UNEXPECTED(oERR_UNEXPECTED),
        .oPERF_STALL_CNT(oPERF_STALL_CNT)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    int checks = 0;
    int errors = 0;
    int n_issue = 0;   // issues seen by the monitor
    int n_sent  = 0;   // responses driven by the bench

    // {rw, tid, addr, data}
    logic [78:0] exp_req [$];
    logic [31:0] exp_resp [$];

    task automatic check(input string tag, input logic [78:0] obs, input logic [78:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic drive_req(input logic rw, input logic [31:0] addr,
                             input logic [31:0] data, input bit accept);
        iEXE_REQ    = 1'b1;
        iEXE_RW     = rw;
        iEXE_ADDR   = addr;
        iEXE_DATA   = data;
        iEXE_TID    = addr[13:0];
        iEXE_ORDER  = 2'b10;
        iEXE_MASK   = 4'hF;
        iEXE_MMUMOD = 2'b01;
        iEXE_PDT    = 32'h0000_1000;
        if (accept) exp_req.push_back({rw, addr[13:0], addr, data});
        step();
        iEXE_REQ = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input bit expected);
        iMEM_VALID = 1'b1;
        iMEM_DATA  = data;
        if (expected) begin
            exp_resp.push_back(data);
            n_sent++;
        end
    endtask

    task automatic do_reset();
        iMEM_VALID = 1'b0;
        iEXE_REQ   = 1'b0;
        inRESET    = 1'b0;
        step();
        inRESET = 1'b1;
        exp_req.delete();
        exp_resp.delete();
        n_sent = n_issue;
    endtask

    // Answers every in-flight request until the queue is empty (bounded).
    task automatic drain(input string tag);
        iMEM_BUSY = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (oQUEUE_EMPTY && (n_issue == n_sent)) break;
            if (n_issue > n_sent) respond(32'hA500_0000 + 32'(n_sent), 1'b1);
            else iMEM_VALID = 1'b0;
            step();
        end
        iMEM_VALID = 1'b0;
        step();
        step();
        check({tag, "_empty"}, oQUEUE_EMPTY, 1'b1);
        check({tag, "_req_left"}, 79'(exp_req.size()), 79'd0);
        check({tag, "_resp_left"}, 79'(exp_resp.size()), 79'd0);
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge iCLOCK) begin
        if (inRESET) begin
            if (oMEM_REQ && !iMEM_BUSY) begin
                n_issue++;
                if (exp_req.size() == 0) check("issue_spurious", oMEM_REQ, 1'b0);
                else check("issue_order", {oMEM_RW, oMEM_TID, oMEM_ADDR, oMEM_DATA},
                           exp_req.pop_front());
            end
            if (oEXE_VALID) begin
                if (exp_resp.size() == 0) check("resp_spurious", oEXE_VALID, 1'b0);
                else check("resp_data", oEXE_DATA, exp_resp.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] exp_stall;

        inRESET = 1'b0;  iEXE_REQ = 1'b0; iEXE_RW = 1'b0; iEXE_ORDER = '0;
        iEXE_MASK = '0;  iEXE_TID = '0;   iEXE_MMUMOD = '0; iEXE_PDT = '0;
        iEXE_ADDR = '0;  iEXE_DATA = '0;  iMEM_BUSY = 1'b0; iMEM_VALID = 1'b0;
        iMEM_DATA = '0;
        step();
        step();
        inRESET = 1'b1;

        // ---- reset state
        check("rst_mem_req", oMEM_REQ, 1'b0);
        check("rst_busy", oEXE_BUSY, 1'b0);
        check("rst_empty", oQUEUE_EMPTY, 1'b1);
        check("rst_valid", oEXE_VALID, 1'b0);
        check("rst_data", oEXE_DATA, 32'h0);
        check("rst_err", oERR_UNEXPECTED, 1'b0);
        check("rst_stall", oPERF_STALL_CNT, 32'h0);

        // ---- single load
        drive_req(1'b0, 32'h100, 32'h0, 1'b1);
        check("load_req_next_cycle", oMEM_REQ, 1'b1);
        check("load_addr", oMEM_ADDR, 32'h100);
        step();                     // issue edge
        step();
        step();
        respond(32'hDEADBEEF, 1'b1); // sampled 3 cycles after issue
        step();
        iMEM_VALID = 1'b0;
        check("load_valid", oEXE_VALID, 1'b1);
        check("load_data", oEXE_DATA, 32'hDEADBEEF);
        step();
        check("load_valid_1cyc", oEXE_VALID, 1'b0);
        check("load_data_hold", oEXE_DATA, 32'hDEADBEEF);
        check("load_empty", oQUEUE_EMPTY, 1'b1);

        // ---- fill with memory busy
        iMEM_BUSY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 32'h200 + 32'(4 * i), 32'h5100 + 32'(i), 1'b1);
            check("fill_busy", oEXE_BUSY, (i == 3));
        end
        drive_req(1'b1, 32'h210, 32'h5104, 1'b0);
        check("fill_5th_busy", oEXE_BUSY, 1'b1);
        check("fill_head_stable", oMEM_ADDR, 32'h200);
        drain("fill");

        // ---- outstanding limit
        base = n_issue;
        drive_req(1'b0, 32'h300, 32'h0, 1'b1);
        drive_req(1'b0, 32'h304, 32'h0, 1'b1);
        drive_req(1'b0, 32'h308, 32'h0, 1'b1);
        step();
        step();
        step();
        check("lim_two_issued", 79'(n_issue - base), 79'd2);
        check("lim_req_low", oMEM_REQ, 1'b0);
        respond(32'h1234_5678, 1'b1);
        step();
        iMEM_VALID = 1'b0;
        check("lim_req_again", oMEM_REQ, 1'b1);
        step();
        check("lim_three_issued", 79'(n_issue - base), 79'd3);
        drain("lim");

        // ---- push, pop and response in the same cycle (count=2, out=1)
        iMEM_BUSY = 1'b1;
        drive_req(1'b0, 32'h400, 32'h0, 1'b1);
        drive_req(1'b1, 32'h404, 32'hC0DE, 1'b1);
        drive_req(1'b0, 32'h408, 32'h0, 1'b1);
        iMEM_BUSY = 1'b0;
        step();                     // issue 0x400: count 2, out 1
        respond(32'h0BAD_F00D, 1'b1);
        drive_req(1'b0, 32'h40C, 32'h0, 1'b1);
        iMEM_VALID = 1'b0;
        iMEM_BUSY  = 1'b1;
        check("sim_valid", oEXE_VALID, 1'b1);
        check("sim_not_full", oEXE_BUSY, 1'b0);
        check("sim_head", oMEM_ADDR, 32'h408);
        step();
        check("sim_valid_1cyc", oEXE_VALID, 1'b0);
        drive_req(1'b1, 32'h410, 32'h7777, 1'b1);
        check("sim_count3", oEXE_BUSY, 1'b0);
        drive_req(1'b0, 32'h414, 32'h0, 1'b1);
        check("sim_count4", oEXE_BUSY, 1'b1);
        drain("sim");

        // ---- unexpected response
        respond(32'hFFFF_0000, 1'b0);
        step();
        iMEM_VALID = 1'b0;
        check("unexp_no_valid", oEXE_VALID, 1'b0);
        check("unexp_err", oERR_UNEXPECTED, 1'b1);
        step();
        step();
        check("unexp_err_sticky", oERR_UNEXPECTED, 1'b1);

        // ---- reset mid-operation: 3 queued, 2 outstanding
        iMEM_BUSY = 1'b0;
        for (int i = 0; i < 5; i++) drive_req(1'b0, 32'h500 + 32'(4 * i), 32'h0, 1'b1);
        check("mid_full_out", oMEM_REQ, 1'b0);
        iMEM_BUSY = 1'b1;
        do_reset();
        check("mid_rst_empty", oQUEUE_EMPTY, 1'b1);
        check("mid_rst_req", oMEM_REQ, 1'b0);
        check("mid_rst_err", oERR_UNEXPECTED, 1'b0);
        check("mid_rst_valid", oEXE_VALID, 1'b0);
        check("mid_rst_data", oEXE_DATA, 32'h0);
        respond(32'h1A7E_0000, 1'b0);
        step();
        iMEM_VALID = 1'b0;
        check("late_resp_err", oERR_UNEXPECTED, 1'b1);
        check("late_resp_no_valid", oEXE_VALID, 1'b0);

        // ---- stall counter: 10 busy cycles with a request pending
        do_reset();
        check("stall_rst", oPERF_STALL_CNT, 32'h0);
        drive_req(1'b0, 32'h600, 32'h0, 1'b1);
        check("stall_before", oPERF_STALL_CNT, 32'h0);
        for (int i = 0; i < 10; i++) step();
`ifdef LDST_DATAIO_QUEUE_STALL_CNT_EN
        exp_stall = 32'd10;
`else
        exp_stall = 32'd0;
`endif
        check("stall_cnt", oPERF_STALL_CNT, exp_stall);
        drain("stall");
        check("stall_hold", oPERF_STALL_CNT, exp_stall);

        do_reset();
        check("final_err_clear", oERR_UNEXPECTED, 1'b0);
        check("final_stall_clear", oPERF_STALL_CNT, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
